adc_spi_cfg_ctrl: RTL and testbench
===================================

// Module: adc_spi_cfg_ctrl
// PURPOSE
//   Sequences the 3-wire SPI configuration port (CSB/SCLK/SDIO) of ADC0. After reset it waits for
//   ADC power-up, then writes a fixed init table. After that it serves single register read/write
//   requests from a host. The requests use a level handshake.
//   Sits beside the DDR capture path in topcount and drives the ADC0_CSB/ADC0_SCLK/ADC0_SDIO pins.
// PARAMETERS
//   CLK_DIV      2     clk cycles per SCLK half-period (>=1)
//   PWRUP_CYCLES 1000  clk cycles to wait after reset release before the first transaction (>=1)
//   CS_GAP       4     minimum clk cycles CSB stays high between transactions (>=1)
// PORTS
//   clk        in   1   system clock; the only clock
//   reset      in   1   asynchronous, active-low (0 = in reset)
//   req        in   1   host request; held high until ack
//   we         in   1   1 = write, 0 = read; stable while req is high
//   addr       in   13  ADC register address; stable while req is high
//   wdata      in   8   write data; stable while req is high
//   ack        out  1   one-cycle pulse when a host transaction completes
//   rdata      out  8   read data; valid from ack, held until the next read completes
//   busy       out  1   1 while in power-up wait, init or a transaction
//   init_done  out  1   set after the last init entry completes; sticky until reset
//   csb        out  1   SPI chip select, active-low
//   sclk       out  1   SPI clock; idles low
//   sdio_out   out  1   SPI data toward the ADC
//   sdio_oe    out  1   1 = drive SDIO; the top-level tri-state buffer uses this
//   sdio_in    in   1   SPI data from the ADC, sampled in clk domain
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-low.
//   Reset values: csb=1, sclk=0, sdio_out=0, sdio_oe=0, ack=0, rdata=0, busy=1, init_done=0.
//   Frame format (24 bits, MSB first):
//     bit23 = R/W (1 = read); bits22:21 = W1W0 = 00; bits20:8 = addr; bits7:0 = data.
//   Init table (all writes, in this order):
//     {0x000,0x18}, {0x014,0x01}, {0x016,0x00}, {0x0FF,0x01}.
//   FSM states:
//     PWRUP   count PWRUP_CYCLES -> LOAD (init index 0).
//     LOAD    latch the frame: init entry, or the host request if init_done=1 and req=1.
//             Otherwise -> IDLE.
//     SETUP   csb=0, sdio_oe=1, sdio_out=bit23, hold for CLK_DIV cycles.
//     SHIFT   per bit: sclk high for CLK_DIV cycles, then sclk low for CLK_DIV cycles.
//             The next bit is presented when sclk falls.
//     HOLD    sclk=0 for CLK_DIV cycles, then csb=1 and sdio_oe=0.
//     GAP     csb=1 for CS_GAP cycles; then go to the next init entry, to LOAD, or to IDLE.
//     IDLE    busy=0; req=1 -> LOAD.
//   Per-frame timing: csb is low for exactly (2 + 48)*CLK_DIV clk cycles. Exactly 24 SCLK rising
//     edges per frame.
//   Read frames:
//     - sdio_oe drops on the falling SCLK edge after bit 8 (the 16th bit) is shifted out.
//     - sdio_in is sampled on each of the last 8 SCLK rising edges, MSB first.
//     - rdata updates when csb rises.
//     - In read frames sdio_out is 0 whenever sdio_oe=0.
//   ack:
//     - High for exactly one cycle, in the cycle csb returns high, for host transactions only.
//     - Never asserted for init entries.
//   init_done and busy: init_done rises in the same cycle csb rises after entry 3. busy falls when
//     the FSM enters IDLE.
//   Arbitration: requests are ignored (no ack) until init_done=1. Init is never pre-empted. req
//     rising during a frame is served after that frame's GAP.
//   Back-to-back requests: if req is still high in the cycle after ack, it is a new request.
//     Service starts after CS_GAP.
//   Reset mid-frame: all outputs go to their reset values immediately. This includes csb=1, which
//     aborts the frame. The sequence restarts from PWRUP.
// TESTING
//   1. Release reset, CLK_DIV=2, PWRUP_CYCLES=10
//      -> first csb fall at cycle 10.
//      -> 4 frames 0x000018, 0x001401, 0x001600, 0x00FF01.
//      -> each frame has csb low 100 cycles and 24 sclk rises.
//      -> init_done=1 after the 4th frame; no ack pulses.
//   2. After init, req=1 we=1 addr=0x015 wdata=0xA5
//      -> frame 0x0015A5.
//      -> one ack pulse.
//      -> busy 0->1->0.
//   3. After init, req=1 we=0 addr=0x001; ADC model returns 0x8C
//      -> header 0x8001.
//      -> sdio_oe=0 for the last 8 bits.
//      -> rdata=0x8C at ack.
//   4. req asserted during init (before init_done)
//      -> no ack until all 4 init frames finish.
//      -> then the request is served.
//   5. req held high through ack (two back-to-back writes)
//      -> csb high >= CS_GAP cycles between frames.
//      -> two acks.
//   6. Reset asserted during bit 12 of an init frame
//      -> csb=1, sclk=0, sdio_oe=0 asynchronously.
//      -> after release the full PWRUP wait and entry 0 repeat.

Source files
------------

// File: rtl/adc_spi_cfg_ctrl_if.sv
// Host request/response channel of the ADC0 SPI configuration controller.
// The host drives a level-held request and gets a one-cycle ack plus read data.
interface adc_spi_cfg_ctrl_if;
    logic        req;
    logic        we;
    logic [12:0] addr;
    logic [7:0]  wdata;
    logic        ack;
    logic [7:0]  rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/adc_spi_cfg_ctrl.sv
// 3-wire SPI sequencer for ADC0: power-up wait, fixed init table, then host
// register reads/writes. All pin outputs are registered from the next state.
module adc_spi_cfg_ctrl #(
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned PWRUP_CYCLES = 1000,
    parameter int unsigned CS_GAP       = 4
) (
    input  logic              clk,
    input  logic              reset,
    adc_spi_cfg_ctrl_if.slave host,
    output logic              busy,
    output logic              init_done,
    output logic              csb,
    output logic              sclk,
    output logic              sdio_out,
    output logic              sdio_oe,
    input  logic              sdio_in
);
    localparam int unsigned MAX_AB  = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int unsigned CNT_MAX = (MAX_AB > PWRUP_CYCLES) ? MAX_AB : PWRUP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t DIV_LAST = cnt_t'(CLK_DIV - 1);
    localparam cnt_t PWR_LAST = cnt_t'(PWRUP_CYCLES - 1);
    localparam cnt_t GAP_LAST = cnt_t'(CS_GAP - 1);

    typedef enum logic [2:0] {PWRUP, LOAD, SETUP, SHIFT, HOLD, GAP, IDLE} state_t;

    state_t      state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    logic        phase_q, phase_d;      // 0 = sclk high half, 1 = sclk low half
    logic [4:0]  bit_q, bit_d;
    logic [1:0]  idx_q, idx_d;
    logic        host_q, host_d;
    logic        rd_q, rd_d;
    logic [23:0] sr_q, sr_d;
    logic [7:0]  rx_q, rx_d;
    logic        ack_q, ack_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        csb_q, csb_d, sclk_q, sclk_d, sdo_q, sdo_d, oe_q, oe_d, busy_q, busy_d;
    logic        in_frame;

    function automatic logic [23:0] init_frame(input logic [1:0] i);
        case (i)
            2'd0:    init_frame = {3'b000, 13'h000, 8'h18};
            2'd1:    init_frame = {3'b000, 13'h014, 8'h01};
            2'd2:    init_frame = {3'b000, 13'h016, 8'h00};
            default: init_frame = {3'b000, 13'h0FF, 8'h01};
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + cnt_t'(1);
        phase_d = phase_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        host_d  = host_q;
        rd_d    = rd_q;
        sr_d    = sr_q;
        rx_d    = rx_q;
        ack_d   = 1'b0;
        rdata_d = rdata_q;
        done_d  = done_q;
        case (state_q)
            PWRUP: if (cnt_q == PWR_LAST) begin
                state_d = LOAD;
                cnt_d   = '0;
            end
            LOAD: begin
                cnt_d   = '0;
                phase_d = 1'b0;
                bit_d   = '0;
                if (!done_q) begin
                    sr_d    = init_frame(idx_q);
                    host_d  = 1'b0;
                    rd_d    = 1'b0;
                    state_d = SETUP;
                end else if (host.req) begin
                    sr_d    = {~host.we, 2'b00, host.addr, host.we ? host.wdata : 8'h00};
                    host_d  = 1'b1;
                    rd_d    = ~host.we;
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: if (cnt_q == DIV_LAST) begin
                state_d = SHIFT;
                cnt_d   = '0;
            end
            SHIFT: if (cnt_q == DIV_LAST) begin
                cnt_d = '0;
                if (!phase_q) begin
                    phase_d = 1'b1;
                    sr_d    = {sr_q[22:0], 1'b0};
                end else if (bit_q == 5'd23) begin
                    state_d = HOLD;
                end else begin
                    phase_d = 1'b0;
                    bit_d   = bit_q + 5'd1;
                    // sample on the rising edges of bits 16..23
                    if (bit_q >= 5'd15) rx_d = {rx_q[6:0], sdio_in};
                end
            end
            HOLD: if (cnt_q == DIV_LAST) begin
                state_d = GAP;
                cnt_d   = '0;
                if (host_q) begin
                    ack_d = 1'b1;
                    if (rd_q) rdata_d = rx_q;
                end else begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) done_d = 1'b1;
                end
            end
            GAP: if (cnt_q == GAP_LAST) begin
                state_d = LOAD;
                cnt_d   = '0;
            end
            default: begin
                cnt_d = '0;
                if (host.req) state_d = LOAD;
            end
        endcase

        in_frame = (state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD);
        csb_d    = ~in_frame;
        sclk_d   = (state_d == SHIFT) && !phase_d;
        oe_d     = in_frame && !(rd_d && ((bit_d > 5'd15) || ((bit_d == 5'd15) && phase_d)));
        sdo_d    = oe_d & sr_d[23];
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= PWRUP;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            bit_q   <= '0;
            idx_q   <= '0;
            host_q  <= 1'b0;
            rd_q    <= 1'b0;
            sr_q    <= '0;
            rx_q    <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            csb_q   <= 1'b1;
            sclk_q  <= 1'b0;
            sdo_q   <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            host_q  <= host_d;
            rd_q    <= rd_d;
            sr_q    <= sr_d;
            rx_q    <= rx_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            csb_q   <= csb_d;
            sclk_q  <= sclk_d;
            sdo_q   <= sdo_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
        end
    end

    assign host.ack   = ack_q;
    assign host.rdata = rdata_q;
    assign busy       = busy_q;
    assign init_done  = done_q;
    assign csb        = csb_q;
    assign sclk       = sclk_q;
    assign sdio_out   = sdo_q;
    assign sdio_oe    = oe_q;
endmodule

// File: tb/tb_adc_spi_cfg_ctrl.sv
// Bench for adc_spi_cfg_ctrl: pin-level SPI monitor + ADC read model, frames
// checked against values computed from the frame format and init table.
module tb_adc_spi_cfg_ctrl;
    localparam int DIV = 2;
    localparam int PWR = 10;
    localparam int GAPC = 4;
    localparam int LOW_LEN = (2 + 48) * DIV;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy, init_done, csb, sclk, sdio_out, sdio_oe;
    logic sdio_in = 1'b0;

    adc_spi_cfg_ctrl_if host_if ();

    adc_spi_cfg_ctrl #(.CLK_DIV(DIV), .PWRUP_CYCLES(PWR), .CS_GAP(GAPC)) dut (
        .clk(clk), .reset(reset), .host(host_if), .busy(busy), .init_done(init_done),
        .csb(csb), .sclk(sclk), .sdio_out(sdio_out), .sdio_oe(sdio_oe), .sdio_in(sdio_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] bits;
        logic [23:0] oe;
        int          rises;
        int          low;
        int          gap;
        logic        ack_at_rise;
        logic        done_at_rise;
    } frame_t;

    frame_t      frames[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          edge_cnt = 0;
    int          first_fall = -1;
    int          ack_total = 0;
    int          oe_viol = 0;
    int          mon_rises = 0;
    logic [7:0]  adc_byte = 8'h00;
    logic [23:0] init_exp [4] = '{24'h000018, 24'h001401, 24'h001600, 24'h00FF01};

    always @(posedge clk or negedge reset)
        if (!reset) edge_cnt <= 0; else edge_cnt <= edge_cnt + 1;

    // Pin monitor and ADC model; sampled on the falling clk edge. Cycle 0 is the
    // first rising edge after reset release.
    logic        prev_csb = 1'b1, prev_sclk = 1'b0;
    int          low = 0, high = 0, cur_gap = 0;
    logic [23:0] bits = '0, oem = '0;
    always @(negedge clk) begin
        if (!reset) begin
            prev_csb = 1'b1; prev_sclk = 1'b0; mon_rises = 0; low = 0; high = 0;
            first_fall = -1; sdio_in = 1'b0;
        end else begin
            if (host_if.ack) ack_total++;
            if (prev_csb && !csb) begin
                if (first_fall < 0) first_fall = edge_cnt - 1;
                cur_gap = high; mon_rises = 0; low = 0; bits = '0; oem = '0;
            end
            if (csb) begin
                if (!prev_csb) high = 1; else high++;
            end else begin
                low++;
                if (!sdio_oe && sdio_out) oe_viol++;
                if (sclk && !prev_sclk) begin
                    mon_rises++;
                    bits = {bits[22:0], sdio_out};
                    oem  = {oem[22:0], sdio_oe};
                end
                if (!sclk && prev_sclk && mon_rises >= 16 && mon_rises < 24)
                    sdio_in = adc_byte[23 - mon_rises];
            end
            if (!prev_csb && csb)
                frames.push_back('{bits, oem, mon_rises, low, cur_gap, host_if.ack, init_done});
            prev_csb = csb; prev_sclk = sclk;
        end
    end

    task automatic release_reset();
        reset = 1'b0;
        host_if.req = 1'b0;
        repeat (3) @(negedge clk);
        frames.delete(); ack_total = 0; oe_viol = 0;
        reset = 1'b1;
    endtask

    task automatic run_host(input logic we, input logic [12:0] addr, input logic [7:0] wdata,
                            output bit got_ack, output bit saw_busy, output bit idle_again,
                            output logic [7:0] rdata_at_ack);
        got_ack = 0; saw_busy = 0; idle_again = 0; rdata_at_ack = 'x;
        frames.delete(); ack_total = 0; oe_viol = 0;
        @(negedge clk);
        host_if.req = 1'b1; host_if.we = we; host_if.addr = addr; host_if.wdata = wdata;
        for (int i = 0; i < 400 && !got_ack; i++) begin
            @(negedge clk);
            if (busy) saw_busy = 1;
            if (host_if.ack) begin
                got_ack = 1; rdata_at_ack = host_if.rdata; host_if.req = 1'b0;
            end
        end
        host_if.req = 1'b0;
        for (int i = 0; i < 30 && !idle_again; i++) begin
            @(negedge clk);
            if (!busy) idle_again = 1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        host_if.req = 1'b0; host_if.we = 1'b0; host_if.addr = '0; host_if.wdata = '0;
        repeat (2) @(negedge clk);
        n_checks += 8;
        if (csb !== 1'b1)       begin n_fail++; $display("FAIL reset_csb: got %b want 1", csb); end
        if (sclk !== 1'b0)      begin n_fail++; $display("FAIL reset_sclk: got %b want 0", sclk); end
        if (sdio_out !== 1'b0)  begin n_fail++; $display("FAIL reset_sdio_out: got %b want 0", sdio_out); end
        if (sdio_oe !== 1'b0)   begin n_fail++; $display("FAIL reset_sdio_oe: got %b want 0", sdio_oe); end
        if (host_if.ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", host_if.ack); end
        if (host_if.rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", host_if.rdata); end
        if (busy !== 1'b1)      begin n_fail++; $display("FAIL reset_busy: got %b want 1", busy); end
        if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b want 0", init_done); end
    endtask

    task automatic test_init();
        bit idle = 0;
        release_reset();
        for (int i = 0; i < 800 && frames.size() < 4; i++) @(negedge clk);
        n_checks++;
        if (frames.size() != 4) begin
            n_fail++; $display("FAIL init_frames: got %0d frames want 4", frames.size());
            return;
        end
        n_checks += 2;
        if (first_fall != PWR) begin n_fail++; $display("FAIL init_first_fall: got %0d want %0d", first_fall, PWR); end
        if (ack_total != 0) begin n_fail++; $display("FAIL init_no_ack: got %0d acks want 0", ack_total); end
        for (int i = 0; i < 4; i++) begin
            n_checks += 4;
            if (frames[i].bits !== init_exp[i])
                begin n_fail++; $display("FAIL init_frame%0d: got %h want %h", i, frames[i].bits, init_exp[i]); end
            if (frames[i].rises != 24 || frames[i].low != LOW_LEN)
                begin n_fail++; $display("FAIL init_timing%0d: got %0d rises %0d low want 24 %0d", i, frames[i].rises, frames[i].low, LOW_LEN); end
            if (frames[i].ack_at_rise !== 1'b0)
                begin n_fail++; $display("FAIL init_ack%0d: got %b want 0", i, frames[i].ack_at_rise); end
            if (frames[i].done_at_rise !== (i == 3))
                begin n_fail++; $display("FAIL init_done%0d: got %b want %b", i, frames[i].done_at_rise, i == 3); end
        end
        for (int i = 0; i < 30 && !idle; i++) begin @(negedge clk); if (!busy) idle = 1; end
        n_checks += 2;
        if (!idle) begin n_fail++; $display("FAIL init_idle: busy still 1 want 0"); end
        if (init_done !== 1'b1) begin n_fail++; $display("FAIL init_done_sticky: got %b want 1", init_done); end
    endtask

    task automatic test_write();
        bit got, sb, idle;
        logic [7:0] rd;
        for (int k = 0; k < 4; k++) begin
            logic [12:0] a = (k == 0) ? 13'h015 : 13'($urandom);
            logic [7:0]  d = (k == 0) ? 8'hA5 : 8'($urandom);
            logic [23:0] exp = (24'(a) << 8) | 24'(d);
            n_checks++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_before%0d: got %b want 0", k, busy); end
            run_host(1'b1, a, d, got, sb, idle, rd);
            n_checks += 5;
            if (!got || !sb || !idle)
                begin n_fail++; $display("FAIL wr_handshake%0d: ack %b busy_seen %b idle %b want 1 1 1", k, got, sb, idle); end
            if (ack_total != 1) begin n_fail++; $display("FAIL wr_ack_count%0d: got %0d want 1", k, ack_total); end
            if (frames.size() != 1) begin n_fail++; $display("FAIL wr_frames%0d: got %0d want 1", k, frames.size()); end
            else begin
                if (frames[0].bits !== exp) begin n_fail++; $display("FAIL wr_frame%0d: got %h want %h", k, frames[0].bits, exp); end
                if (frames[0].ack_at_rise !== 1'b1 || frames[0].oe !== 24'hFFFFFF || frames[0].low != LOW_LEN)
                    begin n_fail++; $display("FAIL wr_shape%0d: ack %b oe %h low %0d want 1 ffffff %0d", k, frames[0].ack_at_rise, frames[0].oe, frames[0].low, LOW_LEN); end
            end
        end
    endtask

    task automatic test_read();
        bit got, sb, idle;
        logic [7:0] rd, last = 8'h00;
        for (int k = 0; k < 4; k++) begin
            logic [12:0] a = (k == 0) ? 13'h001 : 13'($urandom);
            logic [23:0] exp = 24'h800000 | (24'(a) << 8);
            adc_byte = (k == 0) ? 8'h8C : 8'($urandom);
            last = adc_byte;
            run_host(1'b0, a, 8'($urandom), got, sb, idle, rd);
            n_checks += 4;
            if (!got || !idle) begin n_fail++; $display("FAIL rd_handshake%0d: ack %b idle %b want 1 1", k, got, idle); end
            if (rd !== adc_byte) begin n_fail++; $display("FAIL rd_data%0d: got %h want %h", k, rd, adc_byte); end
            if (oe_viol != 0) begin n_fail++; $display("FAIL rd_sdio_out_undriven%0d: got %0d cycles want 0", k, oe_viol); end
            if (frames.size() != 1) begin n_fail++; $display("FAIL rd_frames%0d: got %0d want 1", k, frames.size()); end
            else begin
                n_checks += 2;
                if (frames[0].bits !== exp) begin n_fail++; $display("FAIL rd_frame%0d: got %h want %h", k, frames[0].bits, exp); end
                if (frames[0].oe !== 24'hFFFF00 || frames[0].rises != 24)
                    begin n_fail++; $display("FAIL rd_oe%0d: got %h rises %0d want ffff00 24", k, frames[0].oe, frames[0].rises); end
            end
        end
        adc_byte = ~last;
        run_host(1'b1, 13'($urandom), 8'($urandom), got, sb, idle, rd);
        n_checks++;
        if (host_if.rdata !== last) begin n_fail++; $display("FAIL rd_hold: got %h want %h", host_if.rdata, last); end
    endtask

    task automatic test_req_during_init();
        bit got = 0;
        logic [12:0] a = 13'($urandom);
        logic [7:0]  d = 8'($urandom);
        release_reset();
        host_if.req = 1'b1; host_if.we = 1'b1; host_if.addr = a; host_if.wdata = d;
        for (int i = 0; i < 1200 && !got; i++) begin
            @(negedge clk);
            if (host_if.ack) begin got = 1; host_if.req = 1'b0; end
        end
        host_if.req = 1'b0;
        repeat (3) @(negedge clk);
        n_checks += 3;
        if (!got) begin n_fail++; $display("FAIL early_req_ack: no ack want 1"); end
        if (ack_total != 1) begin n_fail++; $display("FAIL early_req_ack_count: got %0d want 1", ack_total); end
        if (frames.size() != 5) begin n_fail++; $display("FAIL early_req_frames: got %0d want 5", frames.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (frames[i].bits !== init_exp[i] || frames[i].ack_at_rise !== 1'b0)
                    begin n_fail++; $display("FAIL early_req_init%0d: got %h ack %b want %h 0", i, frames[i].bits, frames[i].ack_at_rise, init_exp[i]); end
            end
            n_checks++;
            if (frames[4].bits !== ((24'(a) << 8) | 24'(d)) || frames[4].ack_at_rise !== 1'b1)
                begin n_fail++; $display("FAIL early_req_host: got %h ack %b want %h 1", frames[4].bits, frames[4].ack_at_rise, (24'(a) << 8) | 24'(d)); end
        end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        bit idle = 0;
        logic [12:0] a = 13'($urandom);
        logic [7:0]  d = 8'($urandom);
        logic [23:0] exp = (24'(a) << 8) | 24'(d);
        frames.delete(); ack_total = 0;
        @(negedge clk);
        host_if.req = 1'b1; host_if.we = 1'b1; host_if.addr = a; host_if.wdata = d;
        for (int i = 0; i < 600 && acks < 2; i++) begin
            @(negedge clk);
            if (host_if.ack) acks++;
        end
        host_if.req = 1'b0;
        for (int i = 0; i < 30 && !idle; i++) begin @(negedge clk); if (!busy) idle = 1; end
        n_checks += 3;
        if (acks != 2 || ack_total != 2) begin n_fail++; $display("FAIL b2b_acks: got %0d/%0d want 2", acks, ack_total); end
        if (!idle) begin n_fail++; $display("FAIL b2b_idle: busy still 1 want 0"); end
        if (frames.size() != 2) begin n_fail++; $display("FAIL b2b_frames: got %0d want 2", frames.size()); end
        else begin
            n_checks += 2;
            if (frames[0].bits !== exp || frames[1].bits !== exp)
                begin n_fail++; $display("FAIL b2b_data: got %h %h want %h", frames[0].bits, frames[1].bits, exp); end
            if (frames[1].gap < GAPC) begin n_fail++; $display("FAIL b2b_gap: got %0d want >= %0d", frames[1].gap, GAPC); end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit hit = 0;
        release_reset();
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (!csb && mon_rises == 12) hit = 1;
        end
        n_checks++;
        if (!hit) begin n_fail++; $display("FAIL mid_reset_reach: bit 12 not reached"); end
        #2 reset = 1'b0;
        #1;
        n_checks += 3;
        if (csb !== 1'b1) begin n_fail++; $display("FAIL mid_reset_csb: got %b want 1", csb); end
        if (sclk !== 1'b0) begin n_fail++; $display("FAIL mid_reset_sclk: got %b want 0", sclk); end
        if (sdio_oe !== 1'b0) begin n_fail++; $display("FAIL mid_reset_oe: got %b want 0", sdio_oe); end
        release_reset();
        for (int i = 0; i < 300 && frames.size() < 1; i++) @(negedge clk);
        n_checks += 2;
        if (first_fall != PWR) begin n_fail++; $display("FAIL mid_reset_pwrup: got %0d want %0d", first_fall, PWR); end
        if (frames.size() < 1 || frames[0].bits !== init_exp[0] || frames[0].low != LOW_LEN)
            begin n_fail++; $display("FAIL mid_reset_entry0: frames %0d want entry 000018 with %0d low", frames.size(), LOW_LEN); end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init();
        test_write();
        test_read();
        test_back_to_back();
        test_req_during_init();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
